// File: rtl/motor_pwm_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_driver_if
//  Description : Command, sensor and drive/status bundle for one wheel of
//                the motor PWM driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface motor_pwm_driver_if #(
  parameter int PWM_BITS = 8
);
  logic [2:0]          cmd;      // [2] enable, [1] direction (1=fwd), [0] fast
  logic                stop_in;  // asynchronous obstacle flag
  logic                pwm_a;    // H-bridge forward input
  logic                pwm_b;    // H-bridge reverse input
  logic [PWM_BITS-1:0] duty_o;   // applied duty
  logic [2:0]          state_o;  // FSM state
  logic                estop_o;  // high while in emergency stop

  // System side: issues commands and the sensor flag, observes the bridge.
  modport master (
    output cmd, stop_in,
    input  pwm_a, pwm_b, duty_o, state_o, estop_o
  );

  // Driver side.
  modport slave (
    input  cmd, stop_in,
    output pwm_a, pwm_b, duty_o, state_o, estop_o
  );
endinterface
`default_nettype wire

// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_driver
//  Description : One-wheel H-bridge PWM driver. Soft-start/stop duty ramp,
//                dead-time on direction reversal, synchronised obstacle
//                emergency stop.
//                Optional macro MOTOR_FAST_BRAKE_EN: drive both bridge
//                inputs high in ESTOP (dynamic brake) instead of coasting.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_driver #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 196,
  parameter int RAMP_STEP    = 16,
  parameter int SLOW_DUTY    = 128,
  parameter int FAST_DUTY    = 255,
  parameter int DEAD_PERIODS = 4
) (
  input  wire logic           clk_clk,
  input  wire logic           reset_reset_n,
  motor_pwm_driver_if.slave   bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W = $clog2(DEAD_PERIODS + 1);

  localparam logic [PS_W-1:0]     c_PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] c_PCNT_MAX  = '1;
  localparam logic [PWM_BITS:0]   c_STEP      = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] c_SLOW      = PWM_BITS'(SLOW_DUTY);
  localparam logic [PWM_BITS-1:0] c_FAST      = PWM_BITS'(FAST_DUTY);
  localparam logic [DC_W-1:0]     c_DEAD_LAST = DC_W'(DEAD_PERIODS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_BRAKE = 3'd2,
    ST_DEAD  = 3'd3,
    ST_ESTOP = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                stop_s1_q, stop_s2_q;
  logic [PS_W-1:0]     presc_q;
  logic [PWM_BITS-1:0] pcnt_q;
  logic [PWM_BITS-1:0] cur_q, cur_d;
  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic                pwm_a_q, pwm_a_d;
  logic                pwm_b_q, pwm_b_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_tick;      // one prescaler wrap
  logic                w_bnd;       // PWM period boundary
  logic                w_raw;       // un-registered PWM waveform
  logic                w_en;        // command enable
  logic                w_rev;       // commanded direction differs from latched
  logic                w_stop;      // synchronised obstacle flag
  logic [PWM_BITS-1:0] w_tgt;       // commanded target duty
  logic [PWM_BITS-1:0] w_ramp_run;  // next duty stepping toward w_tgt
  logic [PWM_BITS-1:0] w_ramp_brk;  // next duty stepping toward zero

  // Step cur toward tgt by at most c_STEP, computed one bit wider so that
  // neither the up-step nor the down-step can wrap around.
  function automatic logic [PWM_BITS-1:0] f_ramp(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    logic [PWM_BITS:0] c9;
    logic [PWM_BITS:0] t9;
    logic [PWM_BITS:0] s9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    s9 = c9;
    if (c9 < t9) begin
      s9 = c9 + c_STEP;
      if (s9 > t9) begin
        s9 = t9;
      end
    end else if (c9 > t9) begin
      if ((c9 - t9) <= c_STEP) begin
        s9 = t9;
      end else begin
        s9 = c9 - c_STEP;
      end
    end
    return s9[PWM_BITS-1:0];
  endfunction

  assign w_tick = (presc_q == c_PS_LAST);
  assign w_bnd  = w_tick && (pcnt_q == c_PCNT_MAX);
  assign w_raw  = (pcnt_q < cur_q);
  assign w_en   = bus.cmd[2];
  assign w_rev  = (bus.cmd[1] != dir_q);
  assign w_stop = stop_s2_q;

  // Target duty from the live command word.
  always_comb begin
    w_tgt = '0;
    if (w_en) begin
      w_tgt = bus.cmd[0] ? c_FAST : c_SLOW;
    end
  end

  assign w_ramp_run = f_ramp(cur_q, w_tgt);
  assign w_ramp_brk = f_ramp(cur_q, '0);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous obstacle flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stop_s1_q <= 1'b0;
      stop_s2_q <= 1'b0;
    end else begin
      stop_s1_q <= bus.stop_in;
      stop_s2_q <= stop_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running PWM timebase: prescaler feeding the PWM counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (w_tick) begin
        presc_q <= '0;
        pcnt_q  <= pcnt_q + PWM_BITS'(1);
      end else begin
        presc_q <= presc_q + PS_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state, duty ramp, direction latch and dead-time counter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    dcnt_d  = '0;

    if (w_stop) begin
      // Obstacle wins over everything; duty drops without waiting for a
      // period boundary.
      state_d = ST_ESTOP;
      cur_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cur_d = '0;
          if (w_en) begin
            state_d = w_rev ? ST_DEAD : ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_en && w_rev) begin
            state_d = ST_BRAKE;
            if (w_bnd) begin
              cur_d = w_ramp_brk;
            end
          end else if (w_bnd) begin
            if (!w_en && (cur_q == '0)) begin
              state_d = ST_IDLE;
            end else begin
              cur_d = w_ramp_run;
            end
          end
        end

        ST_BRAKE: begin
          if (!w_rev) begin
            // Reversal withdrawn before the wheel stopped: resume driving.
            state_d = ST_RUN;
            if (w_bnd) begin
              cur_d = w_ramp_run;
            end
          end else if (w_bnd) begin
            if (cur_q == '0) begin
              state_d = ST_DEAD;
            end else begin
              cur_d = w_ramp_brk;
            end
          end
        end

        ST_DEAD: begin
          cur_d  = '0;
          dcnt_d = dcnt_q;
          if (w_bnd) begin
            if (dcnt_q == c_DEAD_LAST) begin
              dcnt_d  = '0;
              dir_d   = bus.cmd[1];
              state_d = w_en ? ST_RUN : ST_IDLE;
            end else begin
              dcnt_d = dcnt_q + DC_W'(1);
            end
          end
        end

        ST_ESTOP: begin
          // Leaving requires software to drop enable first (re-arm).
          cur_d = '0;
          if (!w_en) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cur_d   = '0;
        end
      endcase
    end
  end

  // FSM, duty, direction and dead-time registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      dir_q   <= 1'b1;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bridge drive selection. The stop override also looks at the synchronised
  // flag so the bridge releases on the same edge that enters ESTOP.
  // --------------------------------------------------------------------------
  always_comb begin
    pwm_a_d = 1'b0;
    pwm_b_d = 1'b0;
    if (w_stop || (state_q == ST_ESTOP)) begin
`ifdef MOTOR_FAST_BRAKE_EN
      pwm_a_d = 1'b1;
      pwm_b_d = 1'b1;
`else
      pwm_a_d = 1'b0;
      pwm_b_d = 1'b0;
`endif
    end else if ((state_q == ST_RUN) || (state_q == ST_BRAKE)) begin
      pwm_a_d = dir_q  & w_raw;
      pwm_b_d = ~dir_q & w_raw;
    end
  end

  // Registered bridge outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      pwm_a_q <= pwm_a_d;
      pwm_b_q <= pwm_b_d;
    end
  end

  assign bus.pwm_a   = pwm_a_q;
  assign bus.pwm_b   = pwm_b_q;
  assign bus.duty_o  = cur_q;
  assign bus.state_o = state_q;
  assign bus.estop_o = (state_q == ST_ESTOP);

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_pwm_driver
//  Description : Self-checking bench for motor_pwm_driver with a period-level
//                reference model of the wheel behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_driver;

  localparam int PWM_BITS     = 8;
  localparam int PRESCALE     = 2;
  localparam int RAMP_STEP    = 64;
  localparam int SLOW_DUTY    = 128;
  localparam int FAST_DUTY    = 255;
  localparam int DEAD_PERIODS = 4;
  localparam int PERIOD_CYC   = PRESCALE * (1 << PWM_BITS);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BRAKE = 2;
  localparam int M_DEAD  = 3;
  localparam int M_ESTOP = 4;

`ifdef MOTOR_FAST_BRAKE_EN
  localparam int BRK = 1;
`else
  localparam int BRK = 0;
`endif

  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b0;

  motor_pwm_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  motor_pwm_driver #(
    .PWM_BITS    (PWM_BITS),
    .PRESCALE    (PRESCALE),
    .RAMP_STEP   (RAMP_STEP),
    .SLOW_DUTY   (SLOW_DUTY),
    .FAST_DUTY   (FAST_DUTY),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus)
  );

  always #5 clk_clk = ~clk_clk;

  // Clock edges since reset release; boundaries fall on multiples of a period.
  int cyc;
  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) cyc <= 0;
    else                cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model, advanced once per command change and once per boundary.
  int         m_state;
  int         m_cur;
  int         m_dir;
  int         m_dcnt;
  logic [2:0] m_cmd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_target();
    if (!m_cmd[2]) return 0;
    return m_cmd[0] ? FAST_DUTY : SLOW_DUTY;
  endfunction

  function automatic int m_ramp(input int cur, input int tgt);
    if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
    if (cur > tgt) return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
    return cur;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE; m_cur = 0; m_dir = 1; m_dcnt = 0; m_cmd = 3'b000;
  endtask

  task automatic m_cmd_event();
    int cdir;
    cdir = int'(m_cmd[1]);
    case (m_state)
      M_IDLE:  if (m_cmd[2]) begin
                 if (cdir == m_dir) m_state = M_RUN;
                 else begin m_state = M_DEAD; m_dcnt = 0; end
               end
      M_RUN:   if (m_cmd[2] && cdir != m_dir) m_state = M_BRAKE;
      M_BRAKE: if (cdir == m_dir) m_state = M_RUN;
      M_ESTOP: if (!m_cmd[2]) begin m_state = M_IDLE; m_cur = 0; end
      default: ;
    endcase
  endtask

  task automatic m_boundary();
    case (m_state)
      M_RUN:   if (!m_cmd[2] && m_cur == 0) m_state = M_IDLE;
               else m_cur = m_ramp(m_cur, m_target());
      M_BRAKE: if (m_cur == 0) begin m_state = M_DEAD; m_dcnt = 0; end
               else m_cur = m_ramp(m_cur, 0);
      M_DEAD:  begin
                 m_dcnt++;
                 if (m_dcnt == DEAD_PERIODS) begin
                   m_dir   = int'(m_cmd[1]);
                   m_state = m_cmd[2] ? M_RUN : M_IDLE;
                 end
               end
      default: ;
    endcase
  endtask

  // Advance to just after the next period boundary edge.
  task automatic sync_boundary();
    int n;
    n = 0;
    do begin
      @(posedge clk_clk); #1; n++;
    end while ((cyc % PERIOD_CYC) != 0 && n < 2 * PERIOD_CYC);
    chk("sync_boundary", cyc % PERIOD_CYC, 0);
  endtask

  // Apply a command just after a boundary, run one full period counting the
  // bridge waveform, then compare the post-boundary status.
  task automatic step(input logic [2:0] c);
    int na, nb, nboth, ea, eb;
    bus.cmd = c;
    m_cmd   = c;
    m_cmd_event();
    ea = 0; eb = 0;
    if (m_state == M_RUN || m_state == M_BRAKE) begin
      if (m_dir == 1) ea = PRESCALE * m_cur;
      else            eb = PRESCALE * m_cur;
    end
    na = 0; nb = 0; nboth = 0;
    for (int i = 0; i < PERIOD_CYC; i++) begin
      @(posedge clk_clk); #1;
      if (bus.pwm_a === 1'b1) na++;
      if (bus.pwm_b === 1'b1) nb++;
      if (bus.pwm_a === 1'b1 && bus.pwm_b === 1'b1) nboth++;
    end
    chk("period_align", cyc % PERIOD_CYC, 0);
    chk("pwm_a_high_cycles", na, ea);
    chk("pwm_b_high_cycles", nb, eb);
    chk("pwm_overlap", nboth, 0);
    m_boundary();
    chk("duty_o", bus.duty_o, m_cur);
    chk("state_o", bus.state_o, m_state);
    chk("estop_o", bus.estop_o, 0);
  endtask

  // Bring the wheel to IDLE, then run command c until duty reaches d.
  task automatic drive_to(input logic [2:0] c, input int d);
    int n;
    n = 0;
    while (m_state != M_IDLE && n < 24) begin step(3'b000); n++; end
    n = 0;
    while (!(m_state == M_RUN && m_cur == d) && n < 24) begin step(c); n++; end
    chk("drive_to_duty", bus.duty_o, d);
    chk("drive_to_state", bus.state_o, M_RUN);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd     = 3'b000;
    bus.stop_in = 1'b0;
    m_reset();

    // Reset values while reset is held.
    repeat (3) @(posedge clk_clk);
    #2;
    chk("rst_duty", bus.duty_o, 0);
    chk("rst_state", bus.state_o, M_IDLE);
    chk("rst_estop", bus.estop_o, 0);
    chk("rst_pwm_a", bus.pwm_a, 0);
    chk("rst_pwm_b", bus.pwm_b, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    sync_boundary();

    // Forward fast soft start: 64,128,192,255 then a full period at 255.
    repeat (5) step(3'b111);
    // Soft stop: 191,127,63,0 then IDLE.
    repeat (5) step(3'b000);

    // Reversal from forward slow: brake, dead time, reverse ramp.
    drive_to(3'b110, 128);
    repeat (9) step(3'b100);

    // Randomised command sequence.
    repeat (30) step(3'($urandom_range(0, 7)));

    // Emergency stop while running forward at 192.
    drive_to(3'b111, 192);
    bus.stop_in = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("estop_duty", bus.duty_o, 0);
    chk("estop_state", bus.state_o, M_ESTOP);
    chk("estop_flag", bus.estop_o, 1);
    chk("estop_pwm_a", bus.pwm_a, BRK);
    chk("estop_pwm_b", bus.pwm_b, BRK);
    bus.stop_in = 1'b0;
    repeat (8) @(posedge clk_clk);
    #1;
    chk("estop_hold_state", bus.state_o, M_ESTOP);
    chk("estop_hold_flag", bus.estop_o, 1);
    chk("estop_hold_pwm_a", bus.pwm_a, BRK);
    chk("estop_hold_pwm_b", bus.pwm_b, BRK);
    chk("estop_hold_duty", bus.duty_o, 0);
    bus.cmd = 3'b000;
    repeat (2) @(posedge clk_clk);
    #1;
    chk("rearm_state", bus.state_o, M_IDLE);
    chk("rearm_flag", bus.estop_o, 0);
    chk("rearm_pwm_a", bus.pwm_a, 0);
    chk("rearm_pwm_b", bus.pwm_b, 0);
    m_state = M_IDLE; m_cur = 0; m_cmd = 3'b000;
    sync_boundary();

    // Asynchronous reset mid-operation, reverse at 128 with pwm_b active.
    drive_to(3'b100, 128);
    repeat (100) @(posedge clk_clk);
    #3;
    reset_reset_n = 1'b0;
    #1;
    chk("async_rst_pwm_a", bus.pwm_a, 0);
    chk("async_rst_pwm_b", bus.pwm_b, 0);
    chk("async_rst_duty", bus.duty_o, 0);
    chk("async_rst_state", bus.state_o, M_IDLE);
    chk("async_rst_estop", bus.estop_o, 0);
    bus.cmd = 3'b000;
    #20;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    m_reset();
    sync_boundary();
    // Direction must be forward again and the ramp must start from zero.
    repeat (2) step(3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
